rv32i_core_top: RTL and testbench



---
 rtl/rv32i_core_top.sv | 241 ++++++++++++++++++++++++
 tb/tb_rv32i_core_top.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_core_top.sv
// Single-cycle RV32I execution subsystem: IDLE/RUN/HALT sequencer, core datapath,
// byte-addressed instruction/data memories and cycle/retired-instruction trackers.
module rv32i_core_top #(
  parameter int IMEM_BYTES  = 1024,
  parameter int DMEM_BYTES  = 1024,
  parameter int CYCLE_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clk_en,
  input  logic                   first_fetch_trigger,
  output logic                   done,
  output logic [31:0]            pc,
  output logic [CYCLE_CNT_W-1:0] cycle_count,
  output logic [CYCLE_CNT_W-1:0] instret
);

  localparam int          IAW       = $clog2(IMEM_BYTES);
  localparam int          TAW       = $clog2(IMEM_BYTES + DMEM_BYTES);
  localparam logic [31:0] DMEM_LO   = 32'(IMEM_BYTES);
  localparam logic [31:0] DMEM_HI   = 32'(IMEM_BYTES + DMEM_BYTES);
  localparam logic [31:0] HALT_INSN = 32'h0000006F;
  localparam logic [31:0] NOP_INSN  = 32'h00000013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                 state_reg;
  logic [31:0]            pc_reg;
  logic [31:0]            pc_next;
  logic [31:0]            rf_reg [0:31];
  logic [CYCLE_CNT_W-1:0] cycle_reg;
  logic [CYCLE_CNT_W-1:0] instret_reg;
  logic                   done_reg;

  logic [7:0] imem_ram [0:IMEM_BYTES-1];
  logic [7:0] dmem_ram [IMEM_BYTES:IMEM_BYTES+DMEM_BYTES-1];

  // Unified byte view of the address map; unmapped addresses read as zero.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a < DMEM_LO) return imem_ram[a[IAW-1:0]];
    if (a < DMEM_HI) return dmem_ram[a[TAW-1:0]];
    return 8'h00;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b, input logic alt);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'd0, $signed(a) < $signed(b)};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  logic [31:0] fetch_addr;
  logic [31:0] insn;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] pc_plus4;
  logic        is_halt;
  logic        rd_we;
  logic [31:0] rd_wdata;
  logic        br_taken;
  logic [31:0] ld_addr;
  logic [7:0]  ld_b0, ld_b1, ld_b2, ld_b3;
  logic [31:0] st_addr;
  logic [3:0]  st_mask;
  logic        st_we;
  logic [31:0] lane_addr [0:3];
  logic [3:0]  lane_we;

  assign fetch_addr = {pc_reg[31:2], 2'b00};
  assign insn = (fetch_addr < DMEM_LO)
              ? {mem_byte(fetch_addr + 32'd3), mem_byte(fetch_addr + 32'd2),
                 mem_byte(fetch_addr + 32'd1), mem_byte(fetch_addr)}
              : NOP_INSN;

  assign opcode  = insn[6:0];
  assign rd      = insn[11:7];
  assign f3      = insn[14:12];
  assign rs1     = insn[19:15];
  assign rs2     = insn[24:20];
  assign imm_i   = {{20{insn[31]}}, insn[31:20]};
  assign imm_s   = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b   = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u   = {insn[31:12], 12'd0};
  assign imm_j   = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
  assign rs1_val = rf_reg[rs1];
  assign rs2_val = rf_reg[rs2];
  assign pc_plus4 = pc_reg + 32'd4;
  assign is_halt  = (insn == HALT_INSN);

  always_comb begin
    case (f3)
      3'd0:    br_taken = (rs1_val == rs2_val);
      3'd1:    br_taken = (rs1_val != rs2_val);
      3'd4:    br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'd5:    br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6:    br_taken = (rs1_val <  rs2_val);
      3'd7:    br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Halfword and word accesses are aligned down to their natural size.
  always_comb begin
    ld_addr = rs1_val + imm_i;
    if (f3[1:0] == 2'd1) ld_addr[0] = 1'b0;
    if (f3[1:0] == 2'd2) ld_addr[1:0] = 2'b00;
    st_addr = rs1_val + imm_s;
    if (f3[1:0] == 2'd1) st_addr[0] = 1'b0;
    if (f3[1:0] == 2'd2) st_addr[1:0] = 2'b00;
  end

  assign ld_b0 = mem_byte(ld_addr);
  assign ld_b1 = mem_byte(ld_addr + 32'd1);
  assign ld_b2 = mem_byte(ld_addr + 32'd2);
  assign ld_b3 = mem_byte(ld_addr + 32'd3);

  always_comb begin
    rd_we    = 1'b0;
    rd_wdata = 32'd0;
    pc_next  = pc_plus4;
    st_mask  = 4'b0000;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_reg + imm_u; end
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = (pc_reg + imm_j) & ~32'd3;
      end
      OP_JALR: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = (rs1_val + imm_i) & ~32'd3;
      end
      OP_BRANCH: if (br_taken) pc_next = (pc_reg + imm_b) & ~32'd3;
      OP_LOAD: begin
        rd_we = 1'b1;
        case (f3)
          3'd0:    rd_wdata = {{24{ld_b0[7]}}, ld_b0};
          3'd1:    rd_wdata = {{16{ld_b1[7]}}, ld_b1, ld_b0};
          3'd2:    rd_wdata = {ld_b3, ld_b2, ld_b1, ld_b0};
          3'd4:    rd_wdata = {24'd0, ld_b0};
          3'd5:    rd_wdata = {16'd0, ld_b1, ld_b0};
          default: rd_we = 1'b0;
        endcase
      end
      OP_STORE: begin
        case (f3)
          3'd0:    st_mask = 4'b0001;
          3'd1:    st_mask = 4'b0011;
          3'd2:    st_mask = 4'b1111;
          default: st_mask = 4'b0000;
        endcase
      end
      OP_IMM: begin
        rd_we    = 1'b1;
        rd_wdata = alu(f3, rs1_val, imm_i, (f3 == 3'd5) & insn[30]);
      end
      OP_REG: begin
        rd_we    = 1'b1;
        rd_wdata = alu(f3, rs1_val, rs2_val, insn[30]);
      end
      default: ;
    endcase
  end

  assign st_we = (state_reg == RUN) & clk_en & ~rstn & ~is_halt;

  // Byte lanes outside the data region are silently dropped.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_addr[gi] = st_addr + 32'(gi);
      assign lane_we[gi]   = st_we & st_mask[gi] &
                             (lane_addr[gi] >= DMEM_LO) & (lane_addr[gi] < DMEM_HI);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (lane_we[i]) dmem_ram[lane_addr[i][TAW-1:0]] <= rs2_val[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_reg   <= IDLE;
      pc_reg      <= 32'd0;
      cycle_reg   <= '0;
      instret_reg <= '0;
      done_reg    <= 1'b0;
      for (int i = 0; i < 32; i++) rf_reg[i] <= 32'd0;
    end else if (clk_en) begin
      case (state_reg)
        IDLE: if (first_fetch_trigger) begin
          state_reg <= RUN;
          pc_reg    <= 32'd0;
        end
        RUN: begin
          cycle_reg <= cycle_reg + 1'b1;
          if (is_halt) begin
            state_reg <= HALT;
            done_reg  <= 1'b1;
          end else begin
            pc_reg      <= pc_next;
            instret_reg <= instret_reg + 1'b1;
            if (rd_we && rd != 5'd0) rf_reg[rd] <= rd_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign done        = done_reg;
  assign pc          = pc_reg;
  assign cycle_count = cycle_reg;
  assign instret     = instret_reg;

endmodule

// File: tb/tb_rv32i_core_top.sv
// Directed bench for rv32i_core_top: table of programs with expected counters and
// memory words, plus hand sequences for clock-enable and reset corner cases.
module tb_rv32i_core_top;
  localparam int IMEM = 1024;
  localparam int DMEM = 1024;
  localparam int CW   = 32;
  localparam logic [31:0] HALT = 32'h0000006F;

  logic          clk = 1'b0;
  logic          rstn;
  logic          clk_en;
  logic          trig;
  logic          done;
  logic [31:0]   pc;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instret;

  rv32i_core_top #(.IMEM_BYTES(IMEM), .DMEM_BYTES(DMEM), .CYCLE_CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .clk_en(clk_en), .first_fetch_trigger(trig),
    .done(done), .pc(pc), .cycle_count(cycle_count), .instret(instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else
      $display("ok   %s = %h", name, act);
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] add_r(int rd, int rs1, int rs2);
    return {7'h00, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] lui(int rd, int imm20);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), 7'h37};
  endfunction

  function automatic logic [7:0] pat(int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [31:0] mem_word(int a);
    if (a < IMEM)
      return {dut.imem_ram[a+3], dut.imem_ram[a+2], dut.imem_ram[a+1], dut.imem_ram[a]};
    return {dut.dmem_ram[a+3], dut.dmem_ram[a+2], dut.dmem_ram[a+1], dut.dmem_ram[a]};
  endfunction

  logic [31:0] prog_q[$];

  task automatic build_prog(input int p);
    prog_q.delete();
    case (p)
      0, 1: prog_q = '{addi(3, 0, 1024), addi(1, 0, 5), addi(2, 1, 7), enc_s(0, 2, 3, 2), HALT};
      2: prog_q = '{addi(1, 0, 0), addi(2, 0, 1), addi(4, 0, 11),
                    add_r(1, 1, 2), addi(2, 2, 1), enc_b(-8, 4, 2, 1),
                    addi(3, 0, 1024), enc_s(0, 1, 3, 2), enc_b(6, 0, 0, 0), HALT};
      3: prog_q = '{addi(3, 0, 1024), addi(1, 0, 'h80), enc_s(6, 1, 3, 0),
                    enc_i(6, 3, 0, 2, 7'h03), enc_i(6, 3, 4, 4, 7'h03), enc_i(7, 3, 1, 6, 7'h03),
                    enc_s(8, 2, 3, 2), enc_s(12, 4, 3, 2), enc_s(20, 6, 3, 2),
                    addi(0, 0, 7), enc_s(16, 0, 3, 2), HALT};
      4: prog_q = '{addi(1, 0, 'h55), enc_s(8, 1, 0, 2), lui(3, 1), enc_s(0, 1, 3, 2),
                    enc_i(0, 3, 2, 2, 7'h03), addi(4, 0, 1024), enc_s(0, 2, 4, 2), HALT};
      default: prog_q = '{addi(1, 0, 1), addi(2, 0, 2), addi(3, 0, 3), enc_b(0, 0, 0, 0)};
    endcase
  endtask

  // Holds reset across the backdoor load so no store can race it.
  task automatic reset_and_load(input int p);
    @(negedge clk);
    rstn = 1'b1; clk_en = 1'b1; trig = 1'b0;
    @(negedge clk);
    build_prog(p);
    for (int i = 0; i < IMEM; i++) dut.imem_ram[i] = 8'h00;
    for (int i = IMEM; i < IMEM + DMEM; i++) dut.dmem_ram[i] = pat(i);
    for (int i = 0; i < prog_q.size(); i++) begin
      dut.imem_ram[4*i]   = prog_q[i][7:0];
      dut.imem_ram[4*i+1] = prog_q[i][15:8];
      dut.imem_ram[4*i+2] = prog_q[i][23:16];
      dut.imem_ram[4*i+3] = prog_q[i][31:24];
    end
    @(negedge clk);
  endtask

  task automatic start();
    rstn = 1'b0; clk_en = 1'b1; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && !done; n++) @(negedge clk);
    chk("halt_reached", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    int          budget;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [31:0] pc;
  } prog_exp_t;

  typedef struct {
    int          prog;
    string       name;
    int          addr;
    logic [31:0] exp;
  } mem_chk_t;

  prog_exp_t pexp[5];
  mem_chk_t  mexp[10];

  initial begin
    int nbad;
    rstn = 1'b1; clk_en = 1'b1; trig = 1'b0;

    pexp[0] = '{"basic",   50,  32'd5,  32'd4,  32'd16};
    pexp[1] = '{"gated",   50,  32'd5,  32'd4,  32'd16};
    pexp[2] = '{"loop",    200, 32'd37, 32'd36, 32'd36};
    pexp[3] = '{"bytes",   50,  32'd12, 32'd11, 32'd44};
    pexp[4] = '{"unmapped",50,  32'd8,  32'd7,  32'd28};

    mexp[0] = '{0, "basic_sw",       1024, 32'h0000000C};
    mexp[1] = '{1, "gated_sw",       1024, 32'h0000000C};
    mexp[2] = '{2, "loop_sum",       1024, 32'h00000037};
    mexp[3] = '{3, "lb_sext",        1032, 32'hFFFFFF80};
    mexp[4] = '{3, "lbu_zext",       1036, 32'h00000080};
    mexp[5] = '{3, "x0_zero",        1040, 32'h00000000};
    mexp[6] = '{3, "lh_aligned",     1044, 32'h00003480};
    mexp[7] = '{3, "sb_one_byte",    1028, 32'h3480261F};
    mexp[8] = '{4, "lw_unmapped",    1024, 32'h00000000};
    mexp[9] = '{4, "imem_unchanged", 8,    32'h000011B7};

    for (int p = 0; p < 5; p++) begin
      reset_and_load(p);
      chk({pexp[p].name, "_rst_pc"}, pc, 32'd0);
      chk({pexp[p].name, "_rst_done"}, {31'd0, done}, 32'd0);
      chk({pexp[p].name, "_rst_cyc"}, cycle_count, 32'd0);
      chk({pexp[p].name, "_rst_ret"}, instret, 32'd0);
      start();
      if (p == 0) begin
        chk("start_pc", pc, 32'd0);
        chk("start_cyc", cycle_count, 32'd0);
        @(negedge clk);
        chk("first_pc", pc, 32'd4);
        chk("first_cyc", cycle_count, 32'd1);
      end
      if (p == 1) begin
        repeat (2) @(negedge clk);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("gated_cyc_frozen", cycle_count, 32'd2);
        chk("gated_pc_frozen", pc, 32'd8);
        clk_en = 1'b1;
      end
      wait_done(pexp[p].budget);
      chk({pexp[p].name, "_cycles"}, cycle_count, pexp[p].cyc);
      chk({pexp[p].name, "_instret"}, instret, pexp[p].ret);
      chk({pexp[p].name, "_pc"}, pc, pexp[p].pc);
      for (int m = 0; m < 10; m++)
        if (mexp[m].prog == p) chk(mexp[m].name, mem_word(mexp[m].addr), mexp[m].exp);
      if (p == 4) begin
        nbad = 0;
        for (int i = IMEM + 4; i < IMEM + DMEM; i++)
          if (dut.dmem_ram[i] !== pat(i)) nbad++;
        chk("dmem_untouched", 32'(nbad), 32'd0);
      end
    end

    // Trigger during RUN, reset mid-RUN, trigger lost under clk_en=0, restart.
    reset_and_load(5);
    start();
    repeat (3) @(negedge clk);
    chk("spin_pc", pc, 32'd12);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("run_trig_ignored_pc", pc, 32'd12);
    chk("run_trig_cyc", cycle_count, 32'd4);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    chk("midrun_rst_pc", pc, 32'd0);
    chk("midrun_rst_cyc", cycle_count, 32'd0);
    chk("midrun_rst_ret", instret, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_cyc_hold", cycle_count, 32'd0);
    clk_en = 1'b0; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0; clk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("gated_trig_lost_cyc", cycle_count, 32'd0);
    chk("gated_trig_lost_pc", pc, 32'd0);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
    chk("restart_pc", pc, 32'd4);
    chk("restart_cyc", cycle_count, 32'd1);
    chk("rst_imem_kept", mem_word(0), addi(1, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
